avalon_reg_master: RTL and testbench

- Avalon-MM initiator that drives the UART register slave (or any 32-bit Avalon-MM register slave with waitrequest) from a simple valid/ready command stream.
- Converts one command into one Avalon read or write, obeys waitrequest and samples readdata at a fixed latency.
- Returns exactly one response per command.
- Sits between a host sequencer / debug bridge and the UART register block.

---
 rtl/avalon_reg_master.sv | 197 +++++++++++++++++++
 tb/tb_avalon_reg_master.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_reg_master.sv
// Avalon-MM register initiator: one valid/ready command becomes one Avalon read or write, one response.
// Optional waitrequest timeout is built when AVMM_MASTER_TIMEOUT_EN is defined.
module avalon_reg_master #(
    parameter int ADDR_W         = 3,
    parameter int READ_LATENCY   = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [31:0]       cmd_writedata,
    input  logic [3:0]        cmd_byteenable,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_readdata,
    output logic              rsp_is_write,
    output logic              rsp_error,
    output logic              avmm_write_o,
    output logic              avmm_read_o,
    output logic [ADDR_W-1:0] avmm_address_o,
    output logic [31:0]       avmm_writedata_o,
    output logic [3:0]        avmm_byteenable_o,
    input  logic              avmm_waitrequest_i,
    input  logic [31:0]       avmm_readdata_i
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RDLAT, S_RESP} state_t;

    generate
        if ((READ_LATENCY != 0 && READ_LATENCY != 1) || TIMEOUT_CYCLES < 1) begin : g_bad_param
            $error("avalon_reg_master: READ_LATENCY must be 0 or 1 and TIMEOUT_CYCLES >= 1");
        end
    endgenerate

    state_t            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              avm_write_q, avm_write_d;
    logic              avm_read_q, avm_read_d;
    logic [ADDR_W-1:0] avm_addr_q, avm_addr_d;
    logic [31:0]       avm_wdata_q, avm_wdata_d;
    logic [3:0]        avm_be_q, avm_be_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_is_write_q, rsp_is_write_d;

`ifdef AVMM_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              rsp_error_q, rsp_error_d;
    assign rsp_error = rsp_error_q;
`else
    assign rsp_error = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        cmd_ready_d    = cmd_ready_q;
        avm_write_d    = avm_write_q;
        avm_read_d     = avm_read_q;
        avm_addr_d     = avm_addr_q;
        avm_wdata_d    = avm_wdata_q;
        avm_be_d       = avm_be_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_rdata_d    = rsp_rdata_q;
        rsp_is_write_d = rsp_is_write_q;
`ifdef AVMM_MASTER_TIMEOUT_EN
        tmo_cnt_d      = tmo_cnt_q;
        rsp_error_d    = rsp_error_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d     = S_REQ;
                    cmd_ready_d = 1'b0;
                    avm_write_d = cmd_write;
                    avm_read_d  = ~cmd_write;
                    avm_addr_d  = cmd_address;
                    avm_wdata_d = cmd_writedata;
                    avm_be_d    = cmd_byteenable;
`ifdef AVMM_MASTER_TIMEOUT_EN
                    tmo_cnt_d   = '0;
`endif
                end
            end
            S_REQ: begin
                if (!avmm_waitrequest_i) begin
                    avm_write_d = 1'b0;
                    avm_read_d  = 1'b0;
                    avm_addr_d  = '0;
                    avm_wdata_d = '0;
                    avm_be_d    = '0;
                    if (avm_write_q) begin
                        state_d        = S_RESP;
                        rsp_valid_d    = 1'b1;
                        rsp_is_write_d = 1'b1;
                        rsp_rdata_d    = '0;
`ifdef AVMM_MASTER_TIMEOUT_EN
                        rsp_error_d    = 1'b0;
`endif
                    end else if (READ_LATENCY == 0) begin
                        state_d        = S_RESP;
                        rsp_valid_d    = 1'b1;
                        rsp_is_write_d = 1'b0;
                        rsp_rdata_d    = avmm_readdata_i;
`ifdef AVMM_MASTER_TIMEOUT_EN
                        rsp_error_d    = 1'b0;
`endif
                    end else begin
                        state_d = S_RDLAT;
                    end
                end
`ifdef AVMM_MASTER_TIMEOUT_EN
                // This stall cycle brings the count to TIMEOUT_CYCLES: abandon the transfer.
                else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    avm_write_d    = 1'b0;
                    avm_read_d     = 1'b0;
                    avm_addr_d     = '0;
                    avm_wdata_d    = '0;
                    avm_be_d       = '0;
                    state_d        = S_RESP;
                    rsp_valid_d    = 1'b1;
                    rsp_is_write_d = avm_write_q;
                    rsp_rdata_d    = '0;
                    rsp_error_d    = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
`endif
            end
            S_RDLAT: begin
                state_d        = S_RESP;
                rsp_valid_d    = 1'b1;
                rsp_is_write_d = 1'b0;
                rsp_rdata_d    = avmm_readdata_i;
`ifdef AVMM_MASTER_TIMEOUT_EN
                rsp_error_d    = 1'b0;
`endif
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            cmd_ready_q    <= 1'b1;
            avm_write_q    <= 1'b0;
            avm_read_q     <= 1'b0;
            avm_addr_q     <= '0;
            avm_wdata_q    <= '0;
            avm_be_q       <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            rsp_is_write_q <= 1'b0;
`ifdef AVMM_MASTER_TIMEOUT_EN
            tmo_cnt_q      <= '0;
            rsp_error_q    <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cmd_ready_q    <= cmd_ready_d;
            avm_write_q    <= avm_write_d;
            avm_read_q     <= avm_read_d;
            avm_addr_q     <= avm_addr_d;
            avm_wdata_q    <= avm_wdata_d;
            avm_be_q       <= avm_be_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_is_write_q <= rsp_is_write_d;
`ifdef AVMM_MASTER_TIMEOUT_EN
            tmo_cnt_q      <= tmo_cnt_d;
            rsp_error_q    <= rsp_error_d;
`endif
        end
    end

    assign cmd_ready         = cmd_ready_q;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_readdata      = rsp_rdata_q;
    assign rsp_is_write      = rsp_is_write_q;
    assign avmm_write_o      = avm_write_q;
    assign avmm_read_o       = avm_read_q;
    assign avmm_address_o    = avm_addr_q;
    assign avmm_writedata_o  = avm_wdata_q;
    assign avmm_byteenable_o = avm_be_q;

endmodule

// File: tb/tb_avalon_reg_master.sv
// Bench for avalon_reg_master: instance 0 uses READ_LATENCY 0, instance 1 READ_LATENCY 1; the bench plays the slave.
module tb_avalon_reg_master;

`ifdef AVMM_MASTER_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 1024;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid [2];
    logic        cmd_ready [2];
    logic        cmd_write [2];
    logic [2:0]  cmd_address [2];
    logic [31:0] cmd_writedata [2];
    logic [3:0]  cmd_byteenable [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_readdata [2];
    logic        rsp_is_write [2];
    logic        rsp_error [2];
    logic        avm_write [2];
    logic        avm_read [2];
    logic [2:0]  avm_addr [2];
    logic [31:0] avm_wdata [2];
    logic [3:0]  avm_be [2];
    logic        avm_wait [2];
    logic [31:0] avm_rdata [2];

    int checks = 0;
    int errors = 0;
    logic [31:0] mem_model [2][8];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        avalon_reg_master #(.ADDR_W(3), .READ_LATENCY(gi), .TIMEOUT_CYCLES(TMO)) u_dut (
            .clk(clk), .reset_n(reset_n),
            .cmd_valid(cmd_valid[gi]), .cmd_ready(cmd_ready[gi]), .cmd_write(cmd_write[gi]),
            .cmd_address(cmd_address[gi]), .cmd_writedata(cmd_writedata[gi]),
            .cmd_byteenable(cmd_byteenable[gi]),
            .rsp_valid(rsp_valid[gi]), .rsp_ready(rsp_ready[gi]), .rsp_readdata(rsp_readdata[gi]),
            .rsp_is_write(rsp_is_write[gi]), .rsp_error(rsp_error[gi]),
            .avmm_write_o(avm_write[gi]), .avmm_read_o(avm_read[gi]), .avmm_address_o(avm_addr[gi]),
            .avmm_writedata_o(avm_wdata[gi]), .avmm_byteenable_o(avm_be[gi]),
            .avmm_waitrequest_i(avm_wait[gi]), .avmm_readdata_i(avm_rdata[gi])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present_cmd(input int i, input bit wr, input logic [2:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
        cmd_valid[i]      = 1'b1;
        cmd_write[i]      = wr;
        cmd_address[i]    = addr;
        cmd_writedata[i]  = wdata;
        cmd_byteenable[i] = be;
        check_eq($sformatf("d%0d_cmd_ready_idle", i), 32'(cmd_ready[i]), 32'd1);
        tick();
        cmd_valid[i]      = 1'b0;
        cmd_write[i]      = 1'($urandom);
        cmd_address[i]    = 3'($urandom);
        cmd_writedata[i]  = $urandom;
        cmd_byteenable[i] = 4'($urandom);
    endtask

    // One transaction: expected data from the register-file model, expected timing from
    // the latency rule 2 + stall cycles + (READ_LATENCY for reads).
    task automatic txn(input int i, input bit wr, input logic [2:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int stall, input int rdy_delay, input logic [31:0] junk);
        logic [31:0] exp_rd;
        int lat_exp;
        int n;
        bit got;
        exp_rd  = wr ? 32'd0 : mem_model[i][addr];
        lat_exp = 2 + stall + ((!wr && i == 1) ? 1 : 0);
        present_cmd(i, wr, addr, wdata, be);
        n = 1;
        got = 1'b0;
        while (!got && n <= lat_exp + 20) begin
            avm_wait[i]  = (n <= stall);
            avm_rdata[i] = (n == stall + 1 + i) ? exp_rd : junk;
            if (n <= stall + 1) begin
                check_eq($sformatf("d%0d_req_rd", i), 32'(avm_read[i]), 32'(!wr));
                check_eq($sformatf("d%0d_req_wr", i), 32'(avm_write[i]), 32'(wr));
                check_eq($sformatf("d%0d_req_addr", i), 32'(avm_addr[i]), 32'(addr));
                check_eq($sformatf("d%0d_req_be", i), 32'(avm_be[i]), 32'(be));
                if (wr) check_eq($sformatf("d%0d_req_wdata", i), avm_wdata[i], wdata);
            end else begin
                check_eq($sformatf("d%0d_req_dropped", i), 32'({avm_read[i], avm_write[i]}), 32'd0);
                check_eq($sformatf("d%0d_req_addr_zero", i), 32'(avm_addr[i]), 32'd0);
                check_eq($sformatf("d%0d_req_wdata_zero", i), avm_wdata[i], 32'd0);
            end
            if (rsp_valid[i]) begin
                got = 1'b1;
                check_eq($sformatf("d%0d_latency", i), 32'(n), 32'(lat_exp));
            end else begin
                tick();
                n++;
            end
        end
        check_eq($sformatf("d%0d_rsp_seen", i), 32'(got), 32'd1);
        avm_wait[i] = 1'($urandom);
        if (got) begin
            for (int k = 0; k <= rdy_delay; k++) begin
                check_eq($sformatf("d%0d_rsp_valid", i), 32'(rsp_valid[i]), 32'd1);
                check_eq($sformatf("d%0d_rsp_rdata", i), rsp_readdata[i], exp_rd);
                check_eq($sformatf("d%0d_rsp_is_write", i), 32'(rsp_is_write[i]), 32'(wr));
                check_eq($sformatf("d%0d_rsp_error", i), 32'(rsp_error[i]), 32'd0);
                check_eq($sformatf("d%0d_cmd_ready_busy", i), 32'(cmd_ready[i]), 32'd0);
                if (k < rdy_delay) begin
                    cmd_valid[i] = 1'b1;  // must be ignored while a response is pending
                    tick();
                end
            end
            cmd_valid[i] = 1'b0;
            rsp_ready[i] = 1'b1;
            tick();
            rsp_ready[i] = 1'b0;
            check_eq($sformatf("d%0d_rsp_valid_drop", i), 32'(rsp_valid[i]), 32'd0);
            check_eq($sformatf("d%0d_cmd_ready_back", i), 32'(cmd_ready[i]), 32'd1);
        end
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem_model[i][addr][b*8 +: 8] = wdata[b*8 +: 8];
        end
    endtask

    task automatic check_idle(input string tag, input int i);
        check_eq($sformatf("%s_d%0d_req", tag, i), 32'({avm_read[i], avm_write[i]}), 32'd0);
        check_eq($sformatf("%s_d%0d_addr", tag, i), 32'(avm_addr[i]), 32'd0);
        check_eq($sformatf("%s_d%0d_rsp_valid", tag, i), 32'(rsp_valid[i]), 32'd0);
        check_eq($sformatf("%s_d%0d_cmd_ready", tag, i), 32'(cmd_ready[i]), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            cmd_valid[i] = 1'b0; cmd_write[i] = 1'b0; cmd_address[i] = '0;
            cmd_writedata[i] = '0; cmd_byteenable[i] = '0; rsp_ready[i] = 1'b0;
            avm_wait[i] = 1'b1; avm_rdata[i] = '0;
            for (int a = 0; a < 8; a++) mem_model[i][a] = $urandom;
        end
        reset_n = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            check_idle("reset", i);
            check_eq($sformatf("reset_d%0d_rdata", i), rsp_readdata[i], 32'd0);
            check_eq($sformatf("reset_d%0d_is_write", i), 32'(rsp_is_write[i]), 32'd0);
            check_eq($sformatf("reset_d%0d_error", i), 32'(rsp_error[i]), 32'd0);
            check_eq($sformatf("reset_d%0d_wdata", i), avm_wdata[i], 32'd0);
            check_eq($sformatf("reset_d%0d_be", i), 32'(avm_be[i]), 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 2; i++) check_idle("release", i);

        // Directed cases from the plan
        txn(0, 1'b1, 3'h1, 32'h0123_4567, 4'hF, 0, 0, $urandom);
        mem_model[0][0] = 32'h0000_0A05;
        txn(0, 1'b0, 3'h0, 32'h0, 4'hF, 3, 0, $urandom);
        mem_model[1][5] = 32'h0000_0055;
        txn(1, 1'b0, 3'h5, 32'h0, 4'hF, 0, 0, 32'h0000_DEAD);
        txn(0, 1'b0, 3'h1, 32'h0, 4'hF, 0, 5, $urandom);
        txn(1, 1'b1, 3'h7, 32'hA5A5_5A5A, 4'h5, 2, 5, $urandom);

        // Randomised traffic on both latencies
        for (int k = 0; k < 40; k++) begin
            txn(k % 2, 1'($urandom), 3'($urandom), $urandom, 4'($urandom),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), $urandom);
        end

        // Slave that never releases waitrequest
        present_cmd(0, 1'b0, 3'h2, 32'h0, 4'hF);
        avm_wait[0] = 1'b1;
`ifdef AVMM_MASTER_TIMEOUT_EN
        for (int n = 1; n <= 8; n++) begin
            check_eq("tmo_req_held", 32'(avm_read[0]), 32'd1);
            check_eq("tmo_no_rsp_yet", 32'(rsp_valid[0]), 32'd0);
            tick();
        end
        check_eq("tmo_req_dropped", 32'(avm_read[0]), 32'd0);
        check_eq("tmo_rsp_valid", 32'(rsp_valid[0]), 32'd1);
        check_eq("tmo_rsp_error", 32'(rsp_error[0]), 32'd1);
        check_eq("tmo_rsp_rdata", rsp_readdata[0], 32'd0);
        rsp_ready[0] = 1'b1;
        tick();
        rsp_ready[0] = 1'b0;
        present_cmd(0, 1'b0, 3'h3, 32'h0, 4'hF);
        tick();
`else
        for (int n = 1; n <= 100; n++) begin
            check_eq("stuck_req_held", 32'(avm_read[0]), 32'd1);
            check_eq("stuck_no_rsp", 32'(rsp_valid[0]), 32'd0);
            tick();
        end
`endif
        // Asynchronous reset while a read is stalled in the request phase
        check_eq("midrst_req_before", 32'(avm_read[0]), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("midrst_req_async", 32'(avm_read[0]), 32'd0);
        check_eq("midrst_cmd_ready", 32'(cmd_ready[0]), 32'd1);
        check_eq("midrst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        avm_wait[0] = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick();
            check_idle("post_rst", 0);
        end
        txn(0, 1'b0, 3'h4, 32'h0, 4'hF, 1, 1, $urandom);
        txn(1, 1'b0, 3'h4, 32'h0, 4'hF, 1, 0, $urandom);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%h exp=%h", 32'd1, 32'd0);
        $fatal(1, "bench time limit reached");
    end

endmodule
